// File: rtl/drag_pkg.sv
// Shared drivetrain constants and helpers for the RPM <-> velocity converters.
package drag_pkg;

    localparam int VELOCITY_W  = 19;
    localparam int RPM_W       = 14;
    localparam int DIV_W       = 20;
    localparam int RATIO_W     = 5;
    localparam int CNT_W       = 5;

    localparam int GEAR_RATIO1 = 9;
    localparam int GEAR_RATIO2 = 13;
    localparam int GEAR_RATIO3 = 18;
    localparam int GEAR_RATIO4 = 25;

    localparam int RPM_MIN_DEF = 1000;
    localparam int RPM_MAX_DEF = 8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } vtr_state_e;

    function automatic logic [RATIO_W-1:0] gear_ratio(input logic [1:0] gear);
        logic [RATIO_W-1:0] r;
        case (gear)
            2'd0:    r = RATIO_W'(GEAR_RATIO1);
            2'd1:    r = RATIO_W'(GEAR_RATIO2);
            2'd2:    r = RATIO_W'(GEAR_RATIO3);
            default: r = RATIO_W'(GEAR_RATIO4);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/velocity_to_rpm_if.sv
// Request/result bundle between shift control and the velocity-to-RPM converter.
interface velocity_to_rpm_if;
    import drag_pkg::*;

    logic                  start;
    logic [VELOCITY_W-1:0] velocity;
    logic [1:0]            gear;
    logic                  busy;
    logic                  done;
    logic [RPM_W-1:0]      rpm;
    logic [1:0]            gear_out;
    logic                  clamped;

    modport master (
        output start, velocity, gear,
        input  busy, done, rpm, gear_out, clamped
    );

    modport slave (
        input  start, velocity, gear,
        output busy, done, rpm, gear_out, clamped
    );
endinterface

// File: rtl/velocity_to_rpm_divider.sv
// vtr_divider: 20-bit by 5-bit restoring divider, one quotient bit per tick, MSB first.
module vtr_divider
    import drag_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIV_W-1:0]   dividend,
    input  logic [RATIO_W-1:0] divisor,
    output logic [DIV_W-1:0]   quotient,
    output logic               valid
);
    logic [RATIO_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0]   sh_q, sh_d;
    logic [RATIO_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_q, run_d;
    logic [RATIO_W:0]   trial;
    logic [RATIO_W:0]   diff;
    logic               qbit;

    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    always_comb begin
        rem_d = rem_q;
        sh_d  = sh_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        run_d = run_q;
        trial = {rem_q, sh_q[DIV_W-1]};
        diff  = trial - {1'b0, dvs_q};
        qbit  = (trial >= {1'b0, dvs_q});
        if (load) begin
            rem_d = '0;
            sh_d  = dividend;
            dvs_d = divisor;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            rem_d = qbit ? diff[RATIO_W-1:0] : trial[RATIO_W-1:0];
            sh_d  = {sh_q[DIV_W-2:0], qbit};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DIV_W-1)) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            sh_q  <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            sh_q  <= sh_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // High during the final step; quotient holds the complete result from the next cycle.
    assign valid    = run_q && (cnt_q == CNT_W'(DIV_W-1));
    assign quotient = sh_q;
endmodule

// File: rtl/velocity_to_rpm.sv
// Recomputes engine RPM from velocity on a gear change: rpm = velocity / ratio[gear], clamped.
// Build option: define VTR_ROUND_EN for round-to-nearest instead of truncation.
module velocity_to_rpm
    import drag_pkg::*;
#(
    parameter int RPM_MAX = RPM_MAX_DEF,
    parameter int RPM_MIN = RPM_MIN_DEF
) (
    input  logic              clk100Hz,
    input  logic              rst,
    input  logic              reset_status,
    velocity_to_rpm_if.slave  bus
);
    vtr_state_e         state_q, state_d;
    logic               srst;
    logic               load;
    logic [RATIO_W-1:0] ratio_in;
    logic [DIV_W-1:0]   dividend;
    logic [DIV_W-1:0]   quot;
    logic               div_valid;
    logic [1:0]         gear_q;
    logic [RPM_W-1:0]   rpm_q, rpm_c;
    logic [1:0]         gear_out_q;
    logic               clamped_q, clamp_c;
    logic               done_q;

    assign srst     = rst | reset_status;
    assign ratio_in = gear_ratio(bus.gear);

`ifdef VTR_ROUND_EN
    assign dividend = DIV_W'(bus.velocity) + DIV_W'(ratio_in >> 1);
`else
    assign dividend = DIV_W'(bus.velocity);
`endif

    vtr_divider u_div (
        .clk      (clk100Hz),
        .rst      (srst),
        .load     (load),
        .dividend (dividend),
        .divisor  (ratio_in),
        .quotient (quot),
        .valid    (div_valid)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ST_DIV;
                end
            end
            ST_DIV:  if (div_valid) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rpm_c   = quot[RPM_W-1:0];
        clamp_c = 1'b0;
        if (quot > DIV_W'(RPM_MAX)) begin
            rpm_c   = RPM_W'(RPM_MAX);
            clamp_c = 1'b1;
        end else if (quot < DIV_W'(RPM_MIN)) begin
            rpm_c   = RPM_W'(RPM_MIN);
            clamp_c = 1'b1;
        end
    end

    always_ff @(posedge clk100Hz) begin
        if (srst) begin
            state_q    <= ST_IDLE;
            gear_q     <= '0;
            rpm_q      <= RPM_W'(RPM_MIN);
            gear_out_q <= '0;
            clamped_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_DONE);
            if (load) gear_q <= bus.gear;
            if (state_q == ST_DONE) begin
                rpm_q      <= rpm_c;
                gear_out_q <= gear_q;
                clamped_q  <= clamp_c;
            end
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.rpm      = rpm_q;
    assign bus.gear_out = gear_out_q;
    assign bus.clamped  = clamped_q;
endmodule

// File: tb/tb_velocity_to_rpm.sv
// Self-checking bench for velocity_to_rpm: vector table plus scoreboarded corner sequences.
module tb_velocity_to_rpm;
    logic clk = 1'b0;
    logic rst;
    logic reset_status;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;

    velocity_to_rpm_if vif ();

    velocity_to_rpm dut (
        .clk100Hz     (clk),
        .rst          (rst),
        .reset_status (reset_status),
        .bus          (vif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int rpm;
        int gear;
        int clamped;
        int cyc;
    } sb_t;

    typedef struct {
        int vel;
        int gear;
        int rpm;
        int clamped;
    } vec_t;

    sb_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic sb_t model(input int vel, input int g);
        int ratios[4] = '{9, 13, 18, 25};
        int r;
        int q;
        sb_t e;
        r = ratios[g];
`ifdef VTR_ROUND_EN
        q = (vel + r / 2) / r;
`else
        q = vel / r;
`endif
        e.gear = g;
        e.cyc = 0;
        if (q > 8000)      begin e.rpm = 8000; e.clamped = 1; end
        else if (q < 1000) begin e.rpm = 1000; e.clamped = 1; end
        else               begin e.rpm = q;    e.clamped = 0; end
        return e;
    endfunction

    // Scoreboard: every done pops the oldest expectation, including its due cycle.
    always @(negedge clk) begin
        if (vif.done === 1'b1) begin
            sb_t e;
            done_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("rpm", vif.rpm, e.rpm);
                chk("gear_out", vif.gear_out, e.gear);
                chk("clamped", vif.clamped, e.clamped);
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (vif.busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: got busy=%0d expected 0 within 100 cycles", vif.busy);
        end
    endtask

    task automatic issue(input int vel, input int g, input sb_t e, output int c0);
        sb_t x;
        wait_idle();
        vif.velocity = vel[18:0];
        vif.gear     = g[1:0];
        vif.start    = 1'b1;
        c0 = cyc;
        x = e;
        x.cyc = c0 + 22;
        sbq.push_back(x);
        @(negedge clk);
        vif.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending results expected 0", sbq.size());
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[11];
        sb_t  e;
        int   c0;
        int   dn0;
        int   v;
        int   g;

        tbl[0]  = '{27000,  0, 3000, 0};
        tbl[1]  = '{27000,  3, 1080, 0};
        tbl[2]  = '{524287, 0, 8000, 1};
        tbl[3]  = '{0,      2, 1000, 1};
`ifdef VTR_ROUND_EN
        tbl[4]  = '{27013,  1, 2078, 0};
        tbl[7]  = '{8999,   0, 1000, 0};
`else
        tbl[4]  = '{27013,  1, 2077, 0};
        tbl[7]  = '{8999,   0, 1000, 1};
`endif
        tbl[5]  = '{36000,  2, 2000, 0};
        tbl[6]  = '{9000,   0, 1000, 0};
        tbl[8]  = '{72000,  0, 8000, 0};
        tbl[9]  = '{72009,  0, 8000, 1};
        tbl[10] = '{200000, 3, 8000, 0};

        rst = 1'b1;
        reset_status = 1'b0;
        vif.start = 1'b0;
        vif.velocity = '0;
        vif.gear = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", vif.busy, 0);
        chk("reset_done", vif.done, 0);
        chk("reset_rpm", vif.rpm, 1000);
        chk("reset_gear_out", vif.gear_out, 0);
        chk("reset_clamped", vif.clamped, 0);

        for (int i = 0; i < 11; i++) begin
            e = '{tbl[i].rpm, tbl[i].gear, tbl[i].clamped, 0};
            issue(tbl[i].vel, tbl[i].gear, e, c0);
            if (i == 0) begin
                chk("busy_first_div", vif.busy, 1);
                while (cyc < c0 + 21) @(negedge clk);
                chk("busy_done_state", vif.busy, 1);
                chk("no_early_done", vif.done, 0);
                @(negedge clk);
                chk("busy_in_done_cycle", vif.busy, 0);
                chk("done_pulse", vif.done, 1);
                @(negedge clk);
                chk("done_single", vif.done, 0);
            end
        end
        drain();

        for (int i = 0; i < 5; i++) begin
            v = int'($urandom_range(0, 524287));
            g = int'($urandom_range(0, 3));
            issue(v, g, model(v, g), c0);
        end
        drain();

        // Second start mid-conversion with different inputs must be dropped.
        dn0 = done_cnt;
        issue(27000, 1, model(27000, 1), c0);
        while (cyc < c0 + 5) @(negedge clk);
        vif.velocity = 19'd100000;
        vif.gear     = 2'd3;
        vif.start    = 1'b1;
        @(negedge clk);
        vif.start = 1'b0;
        drain();
        repeat (30) @(negedge clk);
        chk("repulse_done_count", done_cnt - dn0, 1);

        // Abort mid-division via reset_status.
        dn0 = done_cnt;
        issue(36000, 2, model(36000, 2), c0);
        while (cyc < c0 + 11) @(negedge clk);
        reset_status = 1'b1;
        sbq.delete();
        @(negedge clk);
        reset_status = 1'b0;
        chk("abort_busy", vif.busy, 0);
        chk("abort_rpm", vif.rpm, 1000);
        chk("abort_gear_out", vif.gear_out, 0);
        chk("abort_clamped", vif.clamped, 0);
        chk("abort_done", vif.done, 0);
        repeat (25) @(negedge clk);
        chk("abort_no_done", done_cnt - dn0, 0);
        issue(27000, 3, model(27000, 3), c0);
        drain();

        // start held high: accepted every 22 ticks, rpm stable between pulses.
        wait_idle();
        dn0 = done_cnt;
        vif.velocity = 19'd36000;
        vif.gear     = 2'd2;
        vif.start    = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 3; k++) begin
            e = '{2000, 2, 0, c0 + 22 * k};
            sbq.push_back(e);
        end
        while (cyc < c0 + 45) begin
            @(negedge clk);
            if (done_cnt > dn0 && vif.done === 1'b0) chk("hold_rpm_stable", vif.rpm, 2000);
        end
        vif.start = 1'b0;
        drain();
        chk("hold_done_count", done_cnt - dn0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
